// File: rtl/ram_sweep_ctrl_if.sv
// RAM-side bus of the sweep controller: write/read strobe, address, write data, read data.
// The master is the controller; the slave is the RAM it exercises.
interface ram_sweep_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic              mem_rw;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_rw,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_rw,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/ram_sweep_ctrl.sv
// Memory sweep sequencer: fills every RAM word with seed + i*step, reads each back,
// and reports pass/fail, the mismatch count and the lowest failing address.
module ram_sweep_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                start,
  input  logic [DATA_W-1:0]   seed,
  input  logic [DATA_W-1:0]   step,
  ram_sweep_ctrl_if.master    mem,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [ADDR_W:0]     err_count,
  output logic [ADDR_W-1:0]   first_err_addr
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] IDX_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   ERR_ONE = (ADDR_W + 1)'(1);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    RD_ADDR,
    RD_CMP,
    FIN
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] seed_q;
  logic [DATA_W-1:0] step_q;
  logic              rw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              mismatch;

  assign mem.mem_rw    = rw_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;

  // acc always holds exp(idx), so the read compare needs no multiplier
  assign mismatch = (state == RD_CMP) && (mem.mem_rdata != acc);

  always_ff @(posedge clk) begin
    if (clr) begin
      state          <= IDLE;
      idx            <= '0;
      acc            <= '0;
      seed_q         <= '0;
      step_q         <= '0;
      rw_q           <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          rw_q   <= 1'b0;
          addr_q <= '0;
          if (start) begin
            seed_q         <= seed;
            step_q         <= step;
            acc            <= seed;
            idx            <= '0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            rw_q           <= 1'b1;
            addr_q         <= '0;
            wdata_q        <= seed;
            busy           <= 1'b1;
            state          <= WRITE;
          end
        end

        WRITE: begin
          if (idx == LAST) begin
            idx     <= '0;
            acc     <= seed_q;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= seed_q;
            state   <= RD_ADDR;
          end else begin
            idx     <= idx + IDX_ONE;
            acc     <= acc + step_q;
            addr_q  <= idx + IDX_ONE;
            wdata_q <= acc + step_q;
          end
        end

        RD_ADDR: begin
          state <= RD_CMP;
        end

        // Address was already presented in RD_ADDR, so a registered RAM has caught up here
        RD_CMP: begin
          if (mismatch) begin
            err_count <= err_count + ERR_ONE;
            if (err_count == '0) begin
              first_err_addr <= idx;
            end
          end
          if (idx == LAST) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= (err_count == '0) && !mismatch;
            addr_q  <= '0;
            idx     <= '0;
            state   <= FIN;
          end else begin
            idx     <= idx + IDX_ONE;
            acc     <= acc + step_q;
            addr_q  <= idx + IDX_ONE;
            wdata_q <= acc + step_q;
            state   <= RD_ADDR;
          end
        end

        FIN: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_sweep_ctrl.sv
// Bench for ram_sweep_ctrl with a behavioural 8x8 RAM (combinational or registered read,
// optional per-address bit-0 stuck-at-0) and a scoreboard of expected writes and results.
module tb_ram_sweep_ctrl;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       start = 1'b0;
  logic [7:0] seed = 8'h00;
  logic [7:0] step = 8'h00;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] err_count;
  logic [2:0] first_err_addr;

  ram_sweep_ctrl_if #(.DATA_W(8), .ADDR_W(3)) mem_bus ();

  ram_sweep_ctrl #(.DATA_W(8), .ADDR_W(3)) dut (
    .clk           (clk),
    .clr           (clr),
    .start         (start),
    .seed          (seed),
    .step          (step),
    .mem           (mem_bus),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .err_count     (err_count),
    .first_err_addr(first_err_addr)
  );

  always #5 clk = ~clk;

  // RAM model; shares clr with the controller
  logic [7:0] ram [8];
  logic [7:0] rd_q;
  logic [7:0] stuck0 = 8'h00;
  bit         ram_lat = 1'b0;

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 8; i++) ram[i] <= 8'h00;
      rd_q <= 8'h00;
    end else begin
      if (mem_bus.mem_rw) ram[mem_bus.mem_addr] <= mem_bus.mem_wdata;
      rd_q <= ram[mem_bus.mem_addr] & ~{7'b0, stuck0[mem_bus.mem_addr]};
    end
  end

  assign mem_bus.mem_rdata = ram_lat ? rd_q
                           : (ram[mem_bus.mem_addr] & ~{7'b0, stuck0[mem_bus.mem_addr]});

  int total = 0;
  int bad = 0;

  logic [10:0] wr_q [$];
  logic [7:0]  res_q [$];
  logic [10:0] wr_exp;
  logic [7:0]  res_exp;

  // Scoreboard consumer: every write and every done pulse must match a queued expectation
  always @(negedge clk) begin
    if (mem_bus.mem_rw === 1'b1) begin
      total++;
      if (wr_q.size() == 0) begin
        bad++;
        $display("[TB] FAIL write_unexpected got addr=%0d data=%h want none",
                 mem_bus.mem_addr, mem_bus.mem_wdata);
      end else begin
        wr_exp = wr_q.pop_front();
        if ({mem_bus.mem_addr, mem_bus.mem_wdata} !== wr_exp) begin
          bad++;
          $display("[TB] FAIL write got addr=%0d data=%h want addr=%0d data=%h",
                   mem_bus.mem_addr, mem_bus.mem_wdata, wr_exp[10:8], wr_exp[7:0]);
        end
      end
    end
    if (done === 1'b1) begin
      total++;
      if (res_q.size() == 0) begin
        bad++;
        $display("[TB] FAIL done_unexpected got done=1 want 0");
      end else begin
        res_exp = res_q.pop_front();
        if ({pass, err_count, first_err_addr} !== res_exp) begin
          bad++;
          $display("[TB] FAIL result got pass=%0b err=%0d first=%0d want pass=%0b err=%0d first=%0d",
                   pass, err_count, first_err_addr, res_exp[7], res_exp[6:3], res_exp[2:0]);
        end
      end
    end
  end

  task automatic step_cycle();
    @(negedge clk);
    start = 1'b0;
    clr   = 1'b0;
  endtask

  task automatic pulse_start(input logic [7:0] s, input logic [7:0] st, input bit accept);
    logic [7:0] d;
    logic [7:0] rd;
    int         errs;
    int         first;
    start = 1'b1;
    seed  = s;
    step  = st;
    if (accept) begin
      errs  = 0;
      first = 0;
      for (int i = 0; i < 8; i++) begin
        d  = s + 8'(i) * st;
        rd = d & ~{7'b0, stuck0[i]};
        wr_q.push_back({3'(i), d});
        if (rd != d) begin
          if (errs == 0) first = i;
          errs++;
        end
      end
      res_q.push_back({(errs == 0), 4'(errs), 3'(first)});
    end
  endtask

  task automatic run_sweep(input logic [7:0] s, input logic [7:0] st,
                           output int done_cyc, output int busy_errs);
    done_cyc  = -1;
    busy_errs = 0;
    pulse_start(s, st, 1'b1);
    for (int c = 1; c <= 30; c++) begin
      step_cycle();
      if (done === 1'b1 && done_cyc < 0) done_cyc = c;
      if (busy !== 1'(c <= 24)) busy_errs++;
    end
  endtask

  task automatic test_reset();
    clr   = 1'b1;
    start = 1'b1;
    seed  = 8'hAA;
    step  = 8'h01;
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({busy, done, pass, err_count, first_err_addr} !== 10'd0) begin
      bad++;
      $display("[TB] FAIL reset_status got %b want 0", {busy, done, pass, err_count, first_err_addr});
    end
    total++;
    if ({mem_bus.mem_rw, mem_bus.mem_addr, mem_bus.mem_wdata} !== 12'd0) begin
      bad++;
      $display("[TB] FAIL reset_bus got rw=%0b addr=%0d wdata=%h want 0",
               mem_bus.mem_rw, mem_bus.mem_addr, mem_bus.mem_wdata);
    end
    // start was high together with clr: it must not launch a sweep
    step_cycle();
    for (int c = 0; c < 3; c++) begin
      total++;
      if (busy !== 1'b0) begin
        bad++;
        $display("[TB] FAIL clr_start_busy got %b want 0", busy);
      end
      step_cycle();
    end
  endtask

  task automatic test_basic();
    int dc;
    int be;
    run_sweep(8'h10, 8'h01, dc, be);
    total++;
    if (dc !== 25) begin bad++; $display("[TB] FAIL basic_done_cycle got %0d want 25", dc); end
    total++;
    if (be !== 0) begin bad++; $display("[TB] FAIL basic_busy got %0d bad cycles want 0", be); end
    total++;
    if ({pass, err_count, first_err_addr} !== {1'b1, 4'd0, 3'd0}) begin
      bad++;
      $display("[TB] FAIL basic_hold got pass=%0b err=%0d first=%0d want 1/0/0", pass, err_count, first_err_addr);
    end
    total++;
    if (wr_q.size() + res_q.size() !== 0) begin
      bad++;
      $display("[TB] FAIL basic_drain got %0d pending want 0", wr_q.size() + res_q.size());
    end
  endtask

  task automatic test_wrap();
    int dc;
    int be;
    run_sweep(8'hF0, 8'h40, dc, be);
    total++;
    if (dc !== 25 || pass !== 1'b1) begin
      bad++;
      $display("[TB] FAIL wrap got done_cycle=%0d pass=%0b want 25/1", dc, pass);
    end
    total++;
    if (wr_q.size() !== 0) begin bad++; $display("[TB] FAIL wrap_drain got %0d want 0", wr_q.size()); end
  endtask

  task automatic test_fault();
    int dc;
    int be;
    stuck0 = 8'b0010_0000;
    run_sweep(8'h01, 8'h02, dc, be);
    total++;
    if ({pass, err_count, first_err_addr} !== {1'b0, 4'd1, 3'd5}) begin
      bad++;
      $display("[TB] FAIL fault_single got pass=%0b err=%0d first=%0d want 0/1/5", pass, err_count, first_err_addr);
    end
    stuck0 = 8'b0100_1000;
    run_sweep(8'h01, 8'h02, dc, be);
    total++;
    if ({pass, err_count, first_err_addr} !== {1'b0, 4'd2, 3'd3}) begin
      bad++;
      $display("[TB] FAIL fault_double got pass=%0b err=%0d first=%0d want 0/2/3", pass, err_count, first_err_addr);
    end
    stuck0 = 8'b1000_0000;
    run_sweep(8'h01, 8'h02, dc, be);
    total++;
    if ({pass, err_count, first_err_addr} !== {1'b0, 4'd1, 3'd7}) begin
      bad++;
      $display("[TB] FAIL fault_last got pass=%0b err=%0d first=%0d want 0/1/7", pass, err_count, first_err_addr);
    end
    stuck0 = 8'h00;
  endtask

  task automatic test_registered();
    int dc;
    int be;
    ram_lat = 1'b1;
    run_sweep(8'hA5, 8'h11, dc, be);
    total++;
    if (dc !== 25 || pass !== 1'b1 || be !== 0) begin
      bad++;
      $display("[TB] FAIL registered got done_cycle=%0d pass=%0b busy_bad=%0d want 25/1/0", dc, pass, be);
    end
    ram_lat = 1'b0;
  endtask

  task automatic test_back_to_back();
    int ndone;
    int d1;
    int d2;
    ndone = 0;
    d1 = -1;
    d2 = -1;
    pulse_start(8'h33, 8'h05, 1'b1);
    for (int c = 1; c <= 56; c++) begin
      step_cycle();
      if (done === 1'b1) begin
        ndone++;
        if (d1 < 0) d1 = c;
        else if (d2 < 0) d2 = c;
      end
      if (c == 5 || c == 25) pulse_start(8'hC8, 8'h07, 1'b0);
      if (c == 26) pulse_start(8'h44, 8'h09, 1'b1);
    end
    total++;
    if (ndone !== 2 || d1 !== 25 || d2 !== 51) begin
      bad++;
      $display("[TB] FAIL back_to_back got dones=%0d at %0d,%0d want 2 at 25,51", ndone, d1, d2);
    end
  endtask

  task automatic test_reset_mid();
    int dc;
    int be;
    pulse_start(8'h20, 8'h03, 1'b1);
    for (int c = 1; c <= 12; c++) step_cycle();
    clr = 1'b1;
    step_cycle();
    total++;
    if ({busy, done, pass, err_count, first_err_addr, mem_bus.mem_rw, mem_bus.mem_addr, mem_bus.mem_wdata} !== 22'd0) begin
      bad++;
      $display("[TB] FAIL reset_mid got busy=%0b done=%0b pass=%0b err=%0d first=%0d rw=%0b addr=%0d wdata=%h want all 0",
               busy, done, pass, err_count, first_err_addr, mem_bus.mem_rw, mem_bus.mem_addr, mem_bus.mem_wdata);
    end
    wr_q.delete();
    res_q.delete();
    for (int c = 0; c < 15; c++) step_cycle();
    run_sweep(8'h5A, 8'h0D, dc, be);
    total++;
    if (dc !== 25 || pass !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reset_mid_rerun got done_cycle=%0d pass=%0b want 25/1", dc, pass);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_fault();
    test_registered();
    test_back_to_back();
    test_reset_mid();
    repeat (3) step_cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
